// File: rtl/decoder_scan_nbit.sv
// rtl/decoder_scan_nbit.sv - registered N-to-2^N one-hot decoder with dwell-timed sweep sequencer
module decoder_scan_nbit #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N-1:0]      a,
  input  logic              mode,
  input  logic              start,
  input  logic              cont,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              done
);

  localparam int W  = 2**N;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};
  localparam logic [W-1:0]  ONE        = {{(W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWEEP  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  y_q, y_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    y_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (!mode) begin
          idx_d = a;
          if (enable) y_d = ONE << a;
        end else if (start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          dwell_d = '0;
          if (enable) y_d = ONE;
        end
      end
      ST_SWEEP: begin
        // disabled cycles freeze idx/dwell so the remaining dwell resumes later
        if (enable) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (idx_q != IDX_LAST) idx_d = idx_q + N'(1);
            else if (cont)         idx_d = '0;
            else                   state_d = ST_FINISH;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
          if (state_d == ST_SWEEP) y_d = ONE << idx_d;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = (state_q == ST_SWEEP);
  assign done = (state_q == ST_FINISH);

endmodule

// File: tb/tb_decoder_scan_nbit.sv
// tb/tb_decoder_scan_nbit.sv - self-checking bench for decoder_scan_nbit (DWELL=4 and DWELL=1 builds)
module tb_decoder_scan_nbit;

  localparam int DW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, mode, start, cont;
  logic [2:0] a;
  logic [7:0] y;
  logic [2:0] idx;
  logic       busy, done;

  logic       b_reset, b_enable, b_mode, b_start, b_cont;
  logic [2:0] b_a;
  logic [7:0] b_y;
  logic [2:0] b_idx;
  logic       b_busy, b_done;

  decoder_scan_nbit #(.N(3), .DWELL(DW4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .a(a), .mode(mode),
    .start(start), .cont(cont), .y(y), .idx(idx), .busy(busy), .done(done)
  );

  decoder_scan_nbit #(.N(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(b_reset), .enable(b_enable), .a(b_a), .mode(b_mode),
    .start(b_start), .cont(b_cont), .y(b_y), .idx(b_idx), .busy(b_busy), .done(b_done)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    reset = 1'b1; start = 1'b0; enable = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reference model: sweep position counts enabled cycles within a pass
  int         m_state, m_pos, m_idx;
  logic [7:0] m_y;

  task automatic model_step();
    if (reset) begin
      m_state = 0; m_pos = 0; m_idx = 0; m_y = 8'd0;
    end else begin
      case (m_state)
        0: begin
          if (!mode) begin
            m_idx = int'(a);
            m_y   = enable ? (8'd1 << a) : 8'd0;
          end else if (start) begin
            m_state = 1; m_pos = 0; m_idx = 0;
            m_y = enable ? 8'd1 : 8'd0;
          end else begin
            m_y = 8'd0;
          end
        end
        1: begin
          if (!enable) m_y = 8'd0;
          else begin
            m_pos++;
            if (m_pos == 8 * DW4) begin
              if (cont) m_pos = 0;
              else begin
                m_state = 2; m_y = 8'd0;
              end
            end
            if (m_state == 1) begin
              m_idx = m_pos / DW4;
              m_y   = 8'd1 << m_idx;
            end
          end
        end
        default: begin
          m_state = 0; m_y = 8'd0;
        end
      endcase
    end
  endtask

  typedef struct {
    logic [2:0] a;
    logic       en;
    logic [7:0] exp_y;
    logic [2:0] exp_idx;
  } dvec_t;

  dvec_t dvec[9];

  initial begin
    for (int i = 0; i < 8; i++) dvec[i] = '{a: 3'(i), en: 1'b1, exp_y: 8'd1 << i, exp_idx: 3'(i)};
    dvec[8] = '{a: 3'd3, en: 1'b0, exp_y: 8'd0, exp_idx: 3'd3};

    b_reset = 1'b1; b_enable = 1'b0; b_mode = 1'b0; b_start = 1'b0; b_cont = 1'b0; b_a = 3'd0;

    // Reset held with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable = 1'($urandom); mode = 1'($urandom); start = 1'($urandom);
      cont = 1'($urandom); a = 3'($urandom);
      step();
      check("reset_y", y, 0); check("reset_idx", idx, 0);
      check("reset_busy", busy, 0); check("reset_done", done, 0);
    end
    reset = 1'b0; start = 1'b0;

    // Direct mode table
    mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = dvec[i].a; enable = dvec[i].en;
      step();
      check("direct_y", y, dvec[i].exp_y);
      check("direct_idx", idx, dvec[i].exp_idx);
      check("direct_busy", busy, 0);
    end

    // One-shot sweep, stray start at cycle 10
    go_idle();
    mode = 1'b1; cont = 1'b0; enable = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      check("oneshot_y", y, (c <= 32) ? (32'd1 << ((c - 1) / 4)) : 0);
      check("oneshot_busy", busy, (c <= 32) ? 1 : 0);
      check("oneshot_done", done, (c == 33) ? 1 : 0);
      if (c <= 32) check("oneshot_idx", idx, (c - 1) / 4);
      if (c == 33) check("oneshot_idx_end", idx, 7);
      start = (c == 10);
      step();
    end
    start = 1'b0;

    // Pause of 3 cycles while idx=2
    go_idle();
    mode = 1'b1; cont = 1'b0; enable = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      int e;
      e = (c > 13) ? c - 3 : c;
      if (c >= 11 && c <= 13) begin
        check("pause_y", y, 0);
        check("pause_idx", idx, 2);
      end else begin
        check("pause_run_y", y, (e <= 32) ? (32'd1 << ((e - 1) / 4)) : 0);
      end
      check("pause_done", done, (c == 36) ? 1 : 0);
      enable = !(c >= 10 && c <= 12);
      step();
    end
    enable = 1'b1;

    // Continuous mode, cont cleared at cycle 40
    go_idle();
    mode = 1'b1; cont = 1'b1; enable = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      check("cont_y", y, (c <= 64) ? (32'd1 << (((c - 1) % 32) / 4)) : 0);
      check("cont_busy", busy, (c <= 64) ? 1 : 0);
      check("cont_done", done, (c == 65) ? 1 : 0);
      if (c == 40) cont = 1'b0;
      step();
    end

    // Reset mid-sweep at idx=5
    go_idle();
    mode = 1'b1; cont = 1'b0; enable = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 1; c < 22; c++) step();
    check("midreset_pre_idx", idx, 5);
    reset = 1'b1;
    step();
    check("midreset_y", y, 0); check("midreset_idx", idx, 0);
    check("midreset_busy", busy, 0); check("midreset_done", done, 0);
    reset = 1'b0;
    step();
    check("midreset_idle_busy", busy, 0); check("midreset_idle_y", y, 0);

    // Randomized run against the reference model
    reset = 1'b1; step(); reset = 1'b0;
    m_state = 0; m_pos = 0; m_idx = 0; m_y = 8'd0;
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      mode   = ($urandom_range(0, 3) != 0);
      start  = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 7) != 0);
      cont   = 1'($urandom);
      a      = 3'($urandom);
      model_step();
      step();
      check("rand_y", y, m_y);
      check("rand_idx", idx, m_idx);
      check("rand_busy", busy, (m_state == 1) ? 1 : 0);
      check("rand_done", done, (m_state == 2) ? 1 : 0);
    end
    reset = 1'b0; start = 1'b0;

    // DWELL=1 build
    b_reset = 1'b1; step(); b_reset = 1'b0;
    b_mode = 1'b1; b_enable = 1'b1; b_cont = 1'b0; b_start = 1'b1;
    step(); b_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("dwell1_y", b_y, (c <= 8) ? (32'd1 << (c - 1)) : 0);
      check("dwell1_done", b_done, (c == 9) ? 1 : 0);
      check("dwell1_busy", b_busy, (c <= 8) ? 1 : 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
